// File: rtl/expr_pkg.sv
// Shared layout of the packed expression result word: six fields, MSB field first.
// Fields f0/f2/f4 are 4 bits wide and f1/f3/f5 are 6 bits; every field widens to 6 bits on output.
package expr_pkg;

    localparam int NUM_FIELDS = 6;
    localparam int PACK_W     = 30;
    localparam int OUT_W      = 6;
    localparam int IDX_W      = 3;

    localparam int FW  [NUM_FIELDS] = '{4, 6, 4, 6, 4, 6};
    localparam int LSB [NUM_FIELDS] = '{26, 20, 16, 10, 6, 0};

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } unpack_state_t;

endpackage

// File: rtl/expr_field_extract.sv
// Combinational field select: picks field idx from a packed word and widens it to 6 bits.
// Narrow fields sign-extend from bit 3 when their SIGN_MASK bit is set, otherwise they zero-extend.
module expr_field_extract
    import expr_pkg::*;
#(
    parameter logic [NUM_FIELDS-1:0] SIGN_MASK = '0
) (
    input  logic [PACK_W-1:0] word,
    input  logic [IDX_W-1:0]  idx,
    output logic [OUT_W-1:0]  field
);

    logic [OUT_W-1:0] sh;

    always_comb begin
        field = '0;
        sh    = '0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (idx == IDX_W'(i)) begin
                sh = OUT_W'(word >> LSB[i]);
                if (FW[i] == 4) begin
                    field = {{2{SIGN_MASK[i] & sh[3]}}, sh[3:0]};
                end else begin
                    field = sh;
                end
            end
        end
    end

endmodule

// File: rtl/expr_field_unpacker.sv
// Unpacks a 30-bit word into six 6-bit fields, one per cycle; field 0 appears the cycle after accept.
// Outputs hold under out_ready low; a new word is taken only in IDLE or alongside the last field's handshake.
module expr_field_unpacker
    import expr_pkg::*;
#(
    parameter logic [NUM_FIELDS-1:0] SIGN_MASK = '0,
    parameter int                    COUNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PACK_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   out_idx,
    output logic [OUT_W-1:0]   out_field,
    output logic               out_last,
    output logic [COUNT_W-1:0] word_count
);

    unpack_state_t     state;
    logic [PACK_W-1:0] hold;
    logic [IDX_W-1:0]  idx;
    logic              last_xfer;

    // out_ready only reaches in_ready on the final field, so the output side stays registered.
    assign last_xfer = (state == EMIT) && (idx == LAST_IDX) && out_ready;
    assign in_ready  = (state == IDLE) || last_xfer;
    assign out_valid = (state == EMIT);
    assign out_idx   = idx;
    assign out_last  = (state == EMIT) && (idx == LAST_IDX);

    expr_field_extract #(
        .SIGN_MASK (SIGN_MASK)
    ) u_extract (
        .word  (hold),
        .idx   (idx),
        .field (out_field)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hold       <= '0;
            idx        <= '0;
            word_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        hold       <= in_data;
                        idx        <= '0;
                        word_count <= word_count + 1'b1;
                        state      <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (idx != LAST_IDX) begin
                            idx <= idx + 1'b1;
                        end else if (in_valid) begin
                            hold       <= in_data;
                            idx        <= '0;
                            word_count <= word_count + 1'b1;
                        end else begin
                            idx   <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_expr_field_unpacker.sv
// Directed bench: one unpacker with zero-extension and 16-bit counter, one with f0/f2/f4 sign-extended and a 2-bit counter.
module tb_expr_field_unpacker;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [29:0] in_data;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_last;
    logic [2:0]  a_out_idx;
    logic [5:0]  a_out_field;
    logic [15:0] a_word_count;

    logic        b_in_ready, b_out_valid, b_out_last;
    logic [2:0]  b_out_idx;
    logic [5:0]  b_out_field;
    logic [1:0]  b_word_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    expr_field_unpacker #(.SIGN_MASK(6'b000000), .COUNT_W(16)) u_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_idx(a_out_idx), .out_field(a_out_field), .out_last(a_out_last),
        .word_count(a_word_count)
    );

    expr_field_unpacker #(.SIGN_MASK(6'b010101), .COUNT_W(2)) u_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_idx(b_out_idx), .out_field(b_out_field), .out_last(b_out_last),
        .word_count(b_word_count)
    );

    typedef struct {
        logic [2:0] idx;
        logic [5:0] fa;
        logic [5:0] fb;
        logic       last;
    } vec_t;

    vec_t tbl [6];

    localparam logic [29:0] W1 = {4'hA, 6'h15, 4'h3, 6'h3F, 4'h8, 6'h01};
    localparam logic [29:0] W2 = 30'h3FFF_FFFF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers a word while the DUT is idle; returns with field 0 being presented.
    task automatic send_word(input logic [29:0] d);
        in_valid = 1'b1;
        in_data  = d;
        #1;
        chk("accept_in_ready", 32'(a_in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Walks the six table entries with out_ready high.
    task automatic run_table(input string tag);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("%s_valid%0d", tag, k), 32'(a_out_valid), 32'd1);
            chk($sformatf("%s_idx%0d", tag, k), 32'(a_out_idx), 32'(tbl[k].idx));
            chk($sformatf("%s_fa%0d", tag, k), 32'(a_out_field), 32'(tbl[k].fa));
            chk($sformatf("%s_fb%0d", tag, k), 32'(b_out_field), 32'(tbl[k].fb));
            chk($sformatf("%s_last%0d", tag, k), 32'(a_out_last), 32'(tbl[k].last));
            chk($sformatf("%s_inrdy%0d", tag, k), 32'(a_in_ready), 32'(k == 5));
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{3'd0, 6'h0A, 6'h3A, 1'b0};
        tbl[1] = '{3'd1, 6'h15, 6'h15, 1'b0};
        tbl[2] = '{3'd2, 6'h03, 6'h03, 1'b0};
        tbl[3] = '{3'd3, 6'h3F, 6'h3F, 1'b0};
        tbl[4] = '{3'd4, 6'h08, 6'h38, 1'b0};
        tbl[5] = '{3'd5, 6'h01, 6'h01, 1'b1};

        // Reset with in_valid high: nothing may be counted.
        reset = 1'b1; in_valid = 1'b1; in_data = W1; out_ready = 1'b1;
        tick(); tick();
        #1;
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_idx", 32'(a_out_idx), 32'd0);
        chk("rst_out_field", 32'(a_out_field), 32'd0);
        chk("rst_out_last", 32'(a_out_last), 32'd0);
        chk("rst_count", 32'(a_word_count), 32'd0);
        reset = 1'b0; in_valid = 1'b0;
        tick();
        chk("idle_count", 32'(a_word_count), 32'd0);

        // Single word, both sign-extension settings.
        send_word(W1);
        run_table("single");
        #1;
        chk("single_idle", 32'(a_out_valid), 32'd0);
        chk("single_count_a", 32'(a_word_count), 32'd1);
        chk("single_count_b", 32'(b_word_count), 32'd1);
        tick();

        // Back-to-back: W1 then W2 with no bubble.
        in_valid = 1'b1; in_data = W1;
        tick();
        for (int c = 0; c < 12; c++) begin
            in_valid = (c == 5);
            in_data  = W2;
            #1;
            chk($sformatf("b2b_valid%0d", c), 32'(a_out_valid), 32'd1);
            chk($sformatf("b2b_idx%0d", c), 32'(a_out_idx), 32'(c % 6));
            chk($sformatf("b2b_inrdy%0d", c), 32'(a_in_ready), 32'((c % 6) == 5));
            if (c >= 6) begin
                chk($sformatf("b2b_fa%0d", c), 32'(a_out_field), ((c % 2) == 0) ? 32'h0F : 32'h3F);
                chk($sformatf("b2b_fb%0d", c), 32'(b_out_field), 32'h3F);
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("b2b_idle", 32'(a_out_valid), 32'd0);
        chk("b2b_count_a", 32'(a_word_count), 32'd3);
        chk("b2b_count_b", 32'(b_word_count), 32'd3);
        tick();

        // Backpressure at idx 2 for three cycles.
        send_word(W1);
        tick(); tick();
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk($sformatf("bp_idx%0d", s), 32'(a_out_idx), 32'd2);
            chk($sformatf("bp_field%0d", s), 32'(a_out_field), 32'h03);
            chk($sformatf("bp_valid%0d", s), 32'(a_out_valid), 32'd1);
            chk($sformatf("bp_inrdy%0d", s), 32'(a_in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_idx", 32'(a_out_idx), 32'd2);
        tick();
        #1;
        chk("bp_resume_idx", 32'(a_out_idx), 32'd3);
        chk("bp_resume_field", 32'(a_out_field), 32'h3F);
        tick(); tick(); tick();
        #1;
        chk("bp_idle", 32'(a_out_valid), 32'd0);
        chk("bp_count_a", 32'(a_word_count), 32'd4);
        chk("bp_count_b", 32'(b_word_count), 32'd0);
        tick();

        // Reset while idx 4 is presented.
        send_word(W2);
        tick(); tick(); tick(); tick();
        #1;
        chk("mid_idx", 32'(a_out_idx), 32'd4);
        reset = 1'b1;
        tick();
        #1;
        chk("mid_rst_valid", 32'(a_out_valid), 32'd0);
        chk("mid_rst_count", 32'(a_word_count), 32'd0);
        chk("mid_rst_inrdy", 32'(a_in_ready), 32'd1);
        chk("mid_rst_idx", 32'(a_out_idx), 32'd0);
        reset = 1'b0;
        tick();
        send_word(W1);
        run_table("fresh");
        #1;
        chk("fresh_count", 32'(a_word_count), 32'd1);

        // Counter wrap on the 2-bit instance: five words from reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        for (int w = 0; w < 5; w++) begin
            send_word(W2);
            repeat (6) tick();
        end
        #1;
        chk("wrap_count_b", 32'(b_word_count), 32'd1);
        chk("wrap_count_a", 32'(a_word_count), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/expr_field_unpacker.md
# expr_field_unpacker

Stream-side receiver for packed expression result words in the yosys-import regression harness. Accepts one 30-bit word made of six fixed-width fields on a valid/ready input and emits the fields one per cycle, most significant field first, on a valid/ready output. Each field is widened to 6 bits, with per-field sign extension selectable by parameter. Lets the harness compare DUT outputs field-by-field instead of as one opaque vector.

## Interface
- SIGN_MASK, 6'b000000, bit i = 1 sign-extends field i; bit i = 0 zero-extends it.
- COUNT_W, 16, width of the accepted-word counter.

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  packed word present
- in_ready  out  1  unpacker can take a word this cycle
- in_data  in  30  packed word {f0[3:0], f1[5:0], f2[3:0], f3[5:0], f4[3:0], f5[5:0]}; f0 occupies bits 29:26
- out_valid  out  1  field present
- out_ready  in  1  consumer takes field this cycle
- out_idx  out  3  field index, 0..5
- out_field  out  6  field value, widened per SIGN_MASK
- out_last  out  1  asserted with idx 5
- word_count  out  COUNT_W  number of words accepted since reset

## Operation
- Storage: one holding register (30 b), field index counter `idx` (3 b), FSM with states IDLE and EMIT.
- IDLE: in_ready = 1, out_valid = 0. On in_valid, capture in_data, set idx = 0, increment word_count, go to EMIT.
- EMIT: out_valid = 1 and out_idx = idx. out_field is field idx of the held word. 4-bit fields are f0, f2 and f4; each is extended to 6 bits using bit 3 if its SIGN_MASK bit is set, otherwise zeros. 6-bit fields pass unchanged. out_last = (idx == 5).
- On out_valid && out_ready: if idx < 5, idx increments. If idx == 5, the word is complete.
- Back-to-back: in_ready is also 1 in EMIT when idx == 5 && out_ready. If in_valid is high at that point, the new word is captured in the same cycle the last field retires: idx returns to 0 and the FSM stays in EMIT. With no new word, the FSM returns to IDLE.
- in_ready is never asserted in EMIT except on that final handshake cycle. Fields are never dropped or reordered.
- word_count wraps modulo 2^COUNT_W with no saturation.
- out_field, out_idx and out_last hold steady while out_valid && !out_ready.

## Timing
- Reset values: FSM = IDLE, in_ready = 1, out_valid = 0, out_idx = 0, out_field = 0, out_last = 0, word_count = 0, holding register = 0.
- Latency: a word accepted in cycle N presents field 0 in cycle N+1.
- Throughput: with out_ready held high, one word every 6 cycles and no bubbles between words.
- Reset asserted mid-word: the partial word is discarded, and the next cycle shows reset values.
- in_valid during reset is ignored, and no word is counted.
- Output side: valid/ready with no combinational path from out_ready to out_valid.
- Input side: in_ready depends combinationally on out_ready only on the final-field cycle.

## Structure
- Shared package expr_pkg:
  - field width constants FW = '{4,6,4,6,4,6}
  - field LSB offsets '{26,20,16,10,6,0}
  - NUM_FIELDS = 6
  - PACK_W = 30
- One natural sub-module, expr_field_extract: purely combinational. It takes the word, idx and SIGN_MASK and returns the 6-bit widened field. It is reused by the harness packer checker.

## Test plan
- Single word, out_ready = 1: in_data = {4'hA, 6'h15, 4'h3, 6'h3F, 4'h8, 6'h01}, SIGN_MASK = 0.
  - Required out_field sequence: 0x0A, 0x15, 0x03, 0x3F, 0x08, 0x01, on idx 0..5.
  - out_last only on idx 5; word_count = 1.
- Same word with SIGN_MASK = 6'b010101 → f0 = 0x3A, f2 = 0x03, f4 = 0x38; other fields unchanged.
- Back-to-back: two words offered continuously, out_ready = 1.
  - 12 consecutive valid cycles; in_ready pulses on the idx-5 cycle.
  - word_count = 2; no bubble between words.
- Backpressure: out_ready low for 3 cycles at idx 2 → out_idx and out_field stable, in_ready = 0, then the sequence resumes with idx 3.
- Reset at idx 4 → next cycle out_valid = 0, word_count = 0, in_ready = 1. A fresh word then starts at idx 0.
- Counter wrap with COUNT_W = 2: accept 5 words → word_count = 1.
